seq_detector_param: RTL and testbench

- Parametrised serial bit-pattern detector; successor to the fixed 3-state "101" Mealy detector in the FSM library.
- Pattern, length, overlap policy and output timing (Mealy/Moore) are runtime-configurable, with qualified input and a saturating match counter.
- Sits on a 1-bit serial stream (framing/sync-word search, protocol monitors).
- Reset configuration reproduces the legacy overlapping Mealy "101" detector.

---
 rtl/seq_det_pkg.sv | 21 ++
 rtl/seq_detector_param_if.sv | 29 ++
 rtl/seq_det_match_cnt.sv | 28 ++
 rtl/seq_detector_param.sv | 92 +++++++++
 tb/tb_seq_detector_param.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared types, defaults and helpers for the serial pattern detector family.
// Struct fields are sized for the widest supported pattern (CFG_MAX_LEN bits).
package seq_det_pkg;

    function automatic int len_w(input int max_len);
        return $clog2(max_len) + 1;
    endfunction

    localparam int         CFG_MAX_LEN     = 32;
    localparam int         CFG_LEN_W       = len_w(CFG_MAX_LEN);
    localparam logic [7:0] SEQ_DEF_PATTERN = 8'b0000_0101;
    localparam int         SEQ_DEF_LEN     = 3;

    typedef struct packed {
        logic [CFG_MAX_LEN-1:0] pattern;
        logic [CFG_LEN_W-1:0]   len;
        logic                   overlap;
        logic                   moore;
    } seq_cfg_t;

endpackage

// File: rtl/seq_detector_param_if.sv
// Configuration, serial stream and match-report signals of the pattern detector.
interface seq_detector_param_if
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = len_w(MAX_LEN)
);
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cfg_moore;
    logic               in_valid;
    logic               x;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;
    logic               cnt_sat;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap, cfg_moore, in_valid, x,
        input  z, match_cnt, cnt_sat
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, cfg_moore, in_valid, x,
        output z, match_cnt, cnt_sat
    );
endinterface

// File: rtl/seq_det_match_cnt.sv
// Saturating event counter with a sticky overflow flag and synchronous clear.
module seq_det_match_cnt
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (inc) begin
            if (&cnt) begin
                sat <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-configurable serial bit-pattern detector (Mealy/Moore, overlap policy).
// MAX_LEN must lie in 2..CFG_MAX_LEN.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(SEQ_DEF_PATTERN),
    parameter int                 DEF_LEN     = SEQ_DEF_LEN,
    parameter int                 LEN_W       = len_w(MAX_LEN)
) (
    input logic                 clk,
    input logic                 resetn,
    seq_detector_param_if.slave bus
);

    localparam int HIST_W = MAX_LEN - 1;

    seq_cfg_t               cfg_q;
    seq_cfg_t               cfg_in;
    logic [HIST_W-1:0]      hist;
    logic [LEN_W-1:0]       fill;
    logic [LEN_W-1:0]       fill_max;
    logic [CFG_MAX_LEN-1:0] window;
    logic [CFG_MAX_LEN-1:0] mask;
    logic                   accept;
    logic                   len_ok;
    logic                   primed;
    logic                   match_now;
    logic                   z_q;

    always_comb begin
        cfg_in.pattern = CFG_MAX_LEN'(bus.cfg_pattern);
        cfg_in.len     = (bus.cfg_len > LEN_W'(MAX_LEN)) ? CFG_LEN_W'(MAX_LEN)
                                                         : CFG_LEN_W'(bus.cfg_len);
        cfg_in.overlap = bus.cfg_overlap;
        cfg_in.moore   = bus.cfg_moore;
    end

    // Bits of the window above len are stale history; the mask hides them.
    always_comb begin
        accept    = bus.in_valid & ~bus.cfg_load;
        len_ok    = (cfg_q.len != '0);
        fill_max  = LEN_W'(cfg_q.len - CFG_LEN_W'(1));
        primed    = (fill >= fill_max);
        window    = CFG_MAX_LEN'({hist, bus.x});
        mask      = ~({CFG_MAX_LEN{1'b1}} << cfg_q.len);
        match_now = accept & len_ok & primed
                  & (((window ^ cfg_q.pattern) & mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cfg_q.pattern <= CFG_MAX_LEN'(DEF_PATTERN);
            cfg_q.len     <= CFG_LEN_W'(DEF_LEN);
            cfg_q.overlap <= 1'b1;
            cfg_q.moore   <= 1'b0;
            hist          <= '0;
            fill          <= '0;
            z_q           <= 1'b0;
        end else if (bus.cfg_load) begin
            cfg_q <= cfg_in;
            hist  <= '0;
            fill  <= '0;
            z_q   <= 1'b0;
        end else begin
            z_q <= match_now;
            if (accept) begin
                hist <= HIST_W'({hist, bus.x});
                if (match_now && !cfg_q.overlap) begin
                    fill <= '0;
                end else if (len_ok) begin
                    fill <= primed ? fill_max : fill + LEN_W'(1);
                end
            end
        end
    end

    assign bus.z = resetn & (cfg_q.moore ? z_q : match_now);

    seq_det_match_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr    (bus.cfg_load),
        .inc    (match_now),
        .cnt    (bus.match_cnt),
        .sat    (bus.cnt_sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: an 8-bit-counter instance and a 2-bit-counter
// instance receive identical stimulus; each task checks its own scenario inline.
module tb_seq_detector_param;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_pass;

    seq_detector_param_if #(.MAX_LEN(8), .CNT_W(8)) bus ();
    seq_detector_param_if #(.MAX_LEN(8), .CNT_W(2)) bus2 ();

    seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut2 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench still running at %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic adv();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic b);
        bus.in_valid  = v;
        bus.x         = b;
        bus2.in_valid = v;
        bus2.x        = b;
        #1;
    endtask

    task automatic set_cfg(input logic [7:0] p, input logic [3:0] l, input logic ov,
                           input logic mo);
        bus.cfg_pattern  = p;
        bus.cfg_len      = l;
        bus.cfg_overlap  = ov;
        bus.cfg_moore    = mo;
        bus2.cfg_pattern = p;
        bus2.cfg_len     = l;
        bus2.cfg_overlap = ov;
        bus2.cfg_moore   = mo;
    endtask

    task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input logic ov,
                            input logic mo);
        set_cfg(p, l, ov, mo);
        bus.cfg_load  = 1'b1;
        bus2.cfg_load = 1'b1;
        drive(1'b0, 1'b0);
        adv();
        bus.cfg_load  = 1'b0;
        bus2.cfg_load = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive(1'b0, 1'b0);
        adv();
        adv();
        n_checks++;
        if (bus.match_cnt !== 8'd0)
            $display("FAIL reset_cnt: got %0d expected 0", bus.match_cnt);
        else n_pass++;
        n_checks++;
        if (bus.cnt_sat !== 1'b0)
            $display("FAIL reset_sat: got %b expected 0", bus.cnt_sat);
        else n_pass++;
        drive(1'b1, 1'b1);
        n_checks++;
        if (bus.z !== 1'b0)
            $display("FAIL reset_z: got %b expected 0", bus.z);
        else n_pass++;
        drive(1'b0, 1'b0);
        resetn = 1'b1;
    endtask

    task automatic test_mealy_default();
        logic [4:0] bits;
        logic [4:0] exp_z;
        bits  = 5'b10101;
        exp_z = 5'b00101;
        // unloaded config edits must not disturb the reset pattern
        set_cfg(8'hFF, 4'd2, 1'b0, 1'b1);
        for (int i = 4; i >= 0; i--) begin
            drive(1'b1, bits[i]);
            n_checks++;
            if (bus.z !== exp_z[i])
                $display("FAIL mealy_z bit%0d: got %b expected %b", 5 - i, bus.z, exp_z[i]);
            else n_pass++;
            adv();
        end
        drive(1'b0, 1'b0);
        n_checks++;
        if (bus.match_cnt !== 8'd2)
            $display("FAIL mealy_cnt: got %0d expected 2", bus.match_cnt);
        else n_pass++;
    endtask

    task automatic test_overlap();
        logic [6:0] bits;
        logic [6:0] exp_z;
        bits = 7'b1101101;
        for (int pass = 0; pass < 2; pass++) begin
            load_cfg(8'b0000_1101, 4'd4, pass[0], 1'b0);
            n_checks++;
            if (bus.match_cnt !== 8'd0)
                $display("FAIL ovl%0d_load_clr: got %0d expected 0", pass, bus.match_cnt);
            else n_pass++;
            exp_z = (pass == 0) ? 7'b0001000 : 7'b0001001;
            for (int i = 6; i >= 0; i--) begin
                drive(1'b1, bits[i]);
                n_checks++;
                if (bus.z !== exp_z[i])
                    $display("FAIL ovl%0d_z bit%0d: got %b expected %b", pass, 7 - i, bus.z,
                             exp_z[i]);
                else n_pass++;
                adv();
            end
            drive(1'b0, 1'b0);
            n_checks++;
            if (bus.match_cnt !== ((pass == 0) ? 8'd1 : 8'd2))
                $display("FAIL ovl%0d_cnt: got %0d expected %0d", pass, bus.match_cnt,
                         (pass == 0) ? 1 : 2);
            else n_pass++;
        end
    endtask

    task automatic test_moore();
        load_cfg(8'b0000_0101, 4'd3, 1'b1, 1'b1);
        drive(1'b1, 1'b1);
        adv();
        drive(1'b1, 1'b0);
        adv();
        drive(1'b1, 1'b1);
        n_checks++;
        if (bus.z !== 1'b0)
            $display("FAIL moore_z_bit3: got %b expected 0", bus.z);
        else n_pass++;
        n_checks++;
        if (bus.match_cnt !== 8'd0)
            $display("FAIL moore_cnt_pre: got %0d expected 0", bus.match_cnt);
        else n_pass++;
        adv();
        drive(1'b0, 1'b0);
        n_checks++;
        if (bus.z !== 1'b1)
            $display("FAIL moore_z_next: got %b expected 1", bus.z);
        else n_pass++;
        n_checks++;
        if (bus.match_cnt !== 8'd1)
            $display("FAIL moore_cnt_post: got %0d expected 1", bus.match_cnt);
        else n_pass++;
        adv();
        n_checks++;
        if (bus.z !== 1'b0)
            $display("FAIL moore_z_pulse_end: got %b expected 0", bus.z);
        else n_pass++;
    endtask

    task automatic test_gaps();
        load_cfg(8'b0000_0101, 4'd3, 1'b1, 1'b0);
        drive(1'b1, 1'b1);
        adv();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1);
            n_checks++;
            if (bus.z !== 1'b0)
                $display("FAIL gap_z idle%0d: got %b expected 0", i, bus.z);
            else n_pass++;
            adv();
        end
        drive(1'b1, 1'b0);
        adv();
        drive(1'b1, 1'b1);
        n_checks++;
        if (bus.z !== 1'b1)
            $display("FAIL gap_z_final: got %b expected 1", bus.z);
        else n_pass++;
        adv();
        drive(1'b0, 1'b0);
        n_checks++;
        if (bus.match_cnt !== 8'd1)
            $display("FAIL gap_cnt: got %0d expected 1", bus.match_cnt);
        else n_pass++;
        drive(1'b1, 1'b1);
        adv();
        drive(1'b1, 1'b0);
        adv();
        set_cfg(8'b0000_0101, 4'd3, 1'b1, 1'b0);
        bus.cfg_load  = 1'b1;
        bus2.cfg_load = 1'b1;
        drive(1'b1, 1'b1);
        n_checks++;
        if (bus.z !== 1'b0)
            $display("FAIL load_wins_z: got %b expected 0", bus.z);
        else n_pass++;
        adv();
        bus.cfg_load  = 1'b0;
        bus2.cfg_load = 1'b0;
        drive(1'b0, 1'b0);
        n_checks++;
        if (bus.match_cnt !== 8'd0)
            $display("FAIL load_wins_cnt: got %0d expected 0", bus.match_cnt);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [10:0] bits;
        bits = 11'b10101010101;
        load_cfg(8'b0000_0101, 4'd3, 1'b1, 1'b0);
        for (int i = 10; i >= 4; i--) begin
            drive(1'b1, bits[i]);
            adv();
        end
        drive(1'b0, 1'b0);
        n_checks++;
        if (bus2.match_cnt !== 2'd3 || bus2.cnt_sat !== 1'b0)
            $display("FAIL sat_after3: got cnt=%0d sat=%b expected cnt=3 sat=0",
                     bus2.match_cnt, bus2.cnt_sat);
        else n_pass++;
        for (int i = 3; i >= 2; i--) begin
            drive(1'b1, bits[i]);
            adv();
        end
        drive(1'b0, 1'b0);
        n_checks++;
        if (bus2.match_cnt !== 2'd3 || bus2.cnt_sat !== 1'b1)
            $display("FAIL sat_after4: got cnt=%0d sat=%b expected cnt=3 sat=1",
                     bus2.match_cnt, bus2.cnt_sat);
        else n_pass++;
        for (int i = 1; i >= 0; i--) begin
            drive(1'b1, bits[i]);
            adv();
        end
        drive(1'b0, 1'b0);
        n_checks++;
        if (bus2.match_cnt !== 2'd3 || bus2.cnt_sat !== 1'b1)
            $display("FAIL sat_after5: got cnt=%0d sat=%b expected cnt=3 sat=1",
                     bus2.match_cnt, bus2.cnt_sat);
        else n_pass++;
        n_checks++;
        if (bus.match_cnt !== 8'd5)
            $display("FAIL wide_cnt5: got %0d expected 5", bus.match_cnt);
        else n_pass++;
        load_cfg(8'b0000_0101, 4'd3, 1'b1, 1'b0);
        n_checks++;
        if (bus2.match_cnt !== 2'd0 || bus2.cnt_sat !== 1'b0)
            $display("FAIL sat_load_clr: got cnt=%0d sat=%b expected cnt=0 sat=0",
                     bus2.match_cnt, bus2.cnt_sat);
        else n_pass++;
    endtask

    task automatic test_len_edges();
        logic [4:0] bits0;
        logic [7:0] bits8;
        logic [7:0] exp_z;
        bits0 = 5'b10111;
        load_cfg(8'b0000_0101, 4'd0, 1'b1, 1'b0);
        for (int i = 4; i >= 0; i--) begin
            drive(1'b1, bits0[i]);
            n_checks++;
            if (bus.z !== 1'b0)
                $display("FAIL len0_z bit%0d: got %b expected 0", 5 - i, bus.z);
            else n_pass++;
            adv();
        end
        drive(1'b0, 1'b0);
        n_checks++;
        if (bus.match_cnt !== 8'd0)
            $display("FAIL len0_cnt: got %0d expected 0", bus.match_cnt);
        else n_pass++;
        bits8 = 8'b1011_0011;
        exp_z = 8'b0000_0001;
        load_cfg(8'b1011_0011, 4'd15, 1'b1, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            drive(1'b1, bits8[i]);
            n_checks++;
            if (bus.z !== exp_z[i])
                $display("FAIL len15_z bit%0d: got %b expected %b", 8 - i, bus.z, exp_z[i]);
            else n_pass++;
            adv();
        end
        drive(1'b0, 1'b0);
        n_checks++;
        if (bus.match_cnt !== 8'd1)
            $display("FAIL len15_cnt: got %0d expected 1", bus.match_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        load_cfg(8'b0000_0101, 4'd3, 1'b1, 1'b1);
        drive(1'b1, 1'b1);
        adv();
        drive(1'b1, 1'b0);
        adv();
        drive(1'b1, 1'b1);
        adv();
        resetn = 1'b0;
        drive(1'b0, 1'b0);
        n_checks++;
        if (bus.z !== 1'b0)
            $display("FAIL rst_moore_gated: got %b expected 0", bus.z);
        else n_pass++;
        adv();
        resetn = 1'b1;
        drive(1'b0, 1'b0);
        n_checks++;
        if (bus.z !== 1'b0 || bus.match_cnt !== 8'd0)
            $display("FAIL rst_moore_drop: got z=%b cnt=%0d expected z=0 cnt=0", bus.z,
                     bus.match_cnt);
        else n_pass++;
        drive(1'b1, 1'b1);
        adv();
        drive(1'b1, 1'b0);
        adv();
        resetn = 1'b0;
        drive(1'b0, 1'b0);
        adv();
        resetn = 1'b1;
        drive(1'b1, 1'b1);
        n_checks++;
        if (bus.z !== 1'b0)
            $display("FAIL rst_partial_z: got %b expected 0", bus.z);
        else n_pass++;
        adv();
        drive(1'b0, 1'b0);
        n_checks++;
        if (bus.match_cnt !== 8'd0)
            $display("FAIL rst_partial_cnt: got %0d expected 0", bus.match_cnt);
        else n_pass++;
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        resetn        = 1'b0;
        bus.cfg_load  = 1'b0;
        bus2.cfg_load = 1'b0;
        set_cfg(8'h00, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0);
        adv();
        test_reset();
        test_mealy_default();
        test_overlap();
        test_moore();
        test_gaps();
        test_saturation();
        test_len_edges();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
